mm2x2_sequencer: RTL

//  Control FSM for the 2x2 matrix multiplier datapath. On start, it walks the four result

---
 rtl/mm2x2_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mm2x2_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mm2x2_sequencer                                          |
// | Description : Control FSM for a 2x2 matrix multiplier datapath. Walks |
// |               C[0][0], C[0][1], C[1][0], C[1][1]; for each element it |
// |               issues two MAC steps (k=0 with accumulator clear, then  |
// |               k=1), waits MUL_LAT cycles for the multiplier pipeline  |
// |               to drain, then writes the accumulator to the result     |
// |               register. A one-cycle done pulse follows the last write.|
// | Ports       : clk      - system clock, rising edge                    |
// |               mr       - asynchronous active-low master reset         |
// |               ce       - global enable, 0 holds all state             |
// |               start    - begin a multiply (sampled in IDLE only)      |
// |               abort    - cancel the current multiply, no done pulse   |
// |               busy     - 1 in ISSUE0/ISSUE1/DRAIN/WRITE               |
// |               done     - one-cycle pulse after C[1][1] is written     |
// |               row_i    - current result row (A row select)            |
// |               col_j    - current result column (B column select)      |
// |               k_idx    - inner index (A column / B row select)        |
// |               mac_vld  - product enters the datapath this cycle       |
// |               acc_clr  - with mac_vld: load product, do not add       |
// |               res_we   - write accumulator into result register       |
// |               res_addr - {row_i,col_j} write address                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module mm2x2_sequencer #(
   parameter int MUL_LAT = 1
) (
   input  logic       clk,
   input  logic       mr,
   input  logic       ce,
   input  logic       start,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       row_i,
   output logic       col_j,
   output logic       k_idx,
   output logic       mac_vld,
   output logic       acc_clr,
   output logic       res_we,
   output logic [1:0] res_addr
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE0 = 3'd1,
      S_ISSUE1 = 3'd2,
      S_DRAIN  = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Last value of the drain counter before moving on to WRITE.
   localparam logic [1:0] c_drain_last = 2'(MUL_LAT - 1);

   state_t     state_q, state_d;
   logic       row_q, row_d;
   logic       col_q, col_d;
   logic [1:0] cnt_q, cnt_d;
   logic       k_q, k_d;
   logic       mac_q, mac_d;
   logic       clr_q, clr_d;
   logic       we_q, we_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;

   // Next-state logic. Outputs are registered from the next state so every
   // output is a flop (Moore) and lines up with the state it describes.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         row_d   = 1'b0;
         col_d   = 1'b0;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // abort in IDLE suppresses start (abort wins).
               if (start && !abort) begin
                  state_d = S_ISSUE0;
                  row_d   = 1'b0;
                  col_d   = 1'b0;
               end
            end
            S_ISSUE0: state_d = S_ISSUE1;
            S_ISSUE1: begin
               state_d = S_DRAIN;
               cnt_d   = 2'd0;
            end
            S_DRAIN: begin
               if (cnt_q == c_drain_last) begin
                  state_d = S_WRITE;
                  cnt_d   = 2'd0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            S_WRITE: begin
               if ({row_q, col_q} == 2'b11) begin
                  state_d = S_DONE;
                  row_d   = 1'b0;
                  col_d   = 1'b0;
               end else begin
                  {row_d, col_d} = {row_q, col_q} + 2'd1;
                  state_d        = S_ISSUE0;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
               state_d = S_IDLE;
               row_d   = 1'b0;
               col_d   = 1'b0;
               cnt_d   = 2'd0;
            end
         endcase
      end

      mac_d  = (state_d == S_ISSUE0) || (state_d == S_ISSUE1);
      clr_d  = (state_d == S_ISSUE0);
      k_d    = (state_d == S_ISSUE1);
      we_d   = (state_d == S_WRITE);
      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_ISSUE0) || (state_d == S_ISSUE1) ||
               (state_d == S_DRAIN)  || (state_d == S_WRITE);
   end

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         state_q <= S_IDLE;
         row_q   <= 1'b0;
         col_q   <= 1'b0;
         cnt_q   <= 2'd0;
         k_q     <= 1'b0;
         mac_q   <= 1'b0;
         clr_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         mac_q   <= mac_d;
         clr_q   <= clr_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Strobes are masked while ce=0: the held state would otherwise repeat
   // its strobe every frozen cycle. They reappear once ce returns.
   assign mac_vld  = mac_q  & ce;
   assign acc_clr  = clr_q  & ce;
   assign res_we   = we_q   & ce;
   assign done     = done_q & ce;
   assign busy     = busy_q;
   assign row_i    = row_q;
   assign col_j    = col_q;
   assign k_idx    = k_q;
   assign res_addr = {row_q, col_q};

endmodule
`default_nettype wire
